pow_job_queue: RTL and testbench
================================

Name: pow_job_queue

Overview:
Front-end feeder and result collector for the 16-bit square-and-multiply power unit (x^n mod 2^16, start/ready interface).
- Buffers (x, n) requests arriving on a valid/ready stream in an in-order FIFO.
- Issues requests one at a time to the power unit and waits for its completion.
- Captures each result and presents it on a valid/ready output stream, in request order.
- Sits directly upstream of the power unit (drives its start/operands) and consumes its out/ready.

Parameters:
DEPTH, 4, request FIFO entries; power of 2, at least 2
XW, 16, operand/result width; must match the power unit
NW, 8, exponent width; must match the power unit

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high; the power unit's active-low nrst is driven from ~rst at integration
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_x  in  XW  base
in_n  in  NW  exponent
pu_start  out  1  start pulse to power unit
pu_x  out  XW  base to power unit
pu_n  out  NW  exponent to power unit
pu_ready  in  1  power unit idle (combinational in the unit)
pu_out  in  XW  power unit result
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_data  out  XW  result
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count = 0; FSM = IDLE.
  - pu_start=0, out_valid=0, out_data=0, in_ready=1.
  - Asserting rst mid-job abandons the job. The power unit is reset by the same signal.
- FIFO:
  - in_ready = (count < DEPTH), registered-count based; no bypass when full.
  - Push on in_valid && in_ready. Pop only in the ISSUE state.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - A push into an empty FIFO is visible to the FSM the next cycle (no fall-through).
- FSM states: IDLE, ISSUE, WAIT, OUTPUT.
  - IDLE: if count != 0 && pu_ready -> ISSUE; else stay.
  - ISSUE (exactly 1 cycle):
    - pu_start=1; pu_x/pu_n = FIFO head; pop head -> WAIT.
    - pu_x/pu_n are driven from the head in all states; they are don't-care outside ISSUE.
  - WAIT:
    - pu_start=0.
    - pu_ready is sampled from the first cycle after ISSUE. For n=0 it is already 1 there.
    - If pu_ready: out_data <= pu_out, out_valid <= 1 -> OUTPUT.
  - OUTPUT:
    - Hold out_data/out_valid stable until out_ready.
    - On handshake: out_valid <= 0 -> IDLE.
    - No new ISSUE while OUTPUT is occupied.
- Ordering and start rules:
  - Results leave strictly in request order.
  - pu_start is never asserted while pu_ready=0, and never on two consecutive cycles.
- Latency, with a request accepted at cycle 0 into an empty, idle block:
  - ISSUE at cycle 1.
  - The power unit is busy for S cycles, S = popcount(n) + floor(log2 n) for n>0; S = 0 for n=0.
  - out_valid rises at cycle 3+S. Example: n=5 gives S=4, out_valid at cycle 7.
- Arithmetic: the result is the power unit's value (x^n mod 2^XW); this block does no arithmetic.
- Boundary conditions:
  - out_ready held low: the FIFO keeps filling to DEPTH, then in_ready=0. No request or result is lost.
  - A request arriving during WAIT/OUTPUT is queued.

Test Plan:
- Push (x=3, n=5) at cycle 0, out_ready=1 -> pu_start high only in cycle 1; out_valid cycle 7 with out_data=243; count back to 0.
- Push (x=7, n=0) -> out_data=1, out_valid at cycle 3; pu_start pulse exactly 1 cycle.
- Push (2,16), (2,15), (0xFFFF,2), (5,3) back-to-back -> outputs in order 0x0000, 0x8000, 0x0001, 125.
- out_ready=0, push 6 requests -> in_ready low after count=DEPTH (with one request in flight), out_valid/out_data held stable; release out_ready -> all results drain in order, none dropped.
- Push while full with in_valid=1 -> no push, count stays DEPTH; a push coinciding with an ISSUE pop when count=1 -> count stays 1.
- Assert rst during WAIT of (3,200) -> out_valid=0, count=0, pu_start=0 immediately; after release, push (3,2) -> out_data=9.

Source files
------------

// File: rtl/pow_job_queue.sv
// pow_job_queue: request FIFO and result collector wrapped around the 16-bit
// square-and-multiply power unit. Requests (x, n) are queued in order, issued one
// at a time with a single-cycle start pulse, and each result is held on a
// valid/ready output stream until it is consumed.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready         request stream handshake
//   in_x, in_n                request base and exponent
//   pu_start, pu_x, pu_n      start pulse and operands to the power unit
//   pu_ready, pu_out          power unit idle flag and result
//   out_valid/out_ready       result stream handshake
//   out_data                  result value
//   count                     FIFO occupancy
module pow_job_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XW    = 16,
    parameter int unsigned NW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XW-1:0]            in_x,
    input  logic [NW-1:0]            in_n,
    output logic                     pu_start,
    output logic [XW-1:0]            pu_x,
    output logic [NW-1:0]            pu_n,
    input  logic                     pu_ready,
    input  logic [XW-1:0]            pu_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StOutput
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [XW+NW-1:0]  mem_q [DEPTH];
    logic              out_valid_q, out_valid_d;
    logic [XW-1:0]     out_data_q, out_data_d;
    logic              push, pop;

    // Ready depends only on the registered count: no bypass when full.
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;

    // Operands always come from the head; the unit only looks at them on start.
    assign pu_x = mem_q[rptr_q][XW+NW-1:NW];
    assign pu_n = mem_q[rptr_q][NW-1:0];

    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Storage needs no reset: entries are only read once the count says they exist.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {in_x, in_n};
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pu_start    = 1'b0;
        pop         = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0 && pu_ready) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                pu_start = 1'b1;
                pop      = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                // The unit is idle again (or never left idle for n=0): capture.
                if (pu_ready) begin
                    out_data_d  = pu_out;
                    out_valid_d = 1'b1;
                    state_d     = StOutput;
                end
            end
            StOutput: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pow_job_queue.sv
// Directed bench for pow_job_queue. A small behavioural power unit stands in for
// the real one: it goes busy for popcount(n)+floor(log2 n) cycles after start.
// Cycle 0 is the cycle right after the edge that accepts a request.
module tb_pow_job_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [7:0]  in_n;
    logic        pu_start;
    logic [15:0] pu_x;
    logic [7:0]  pu_n;
    logic        pu_ready;
    logic [15:0] pu_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  count;

    int tests  = 0;
    int failed = 0;

    pow_job_queue #(
        .DEPTH (4),
        .XW    (16),
        .NW    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_n      (in_n),
        .pu_start  (pu_start),
        .pu_x      (pu_x),
        .pu_n      (pu_n),
        .pu_ready  (pu_ready),
        .pu_out    (pu_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural power unit ----------------
    logic [7:0]  pu_busy;
    logic [15:0] pu_res;

    function automatic logic [7:0] busy_of(input logic [7:0] n);
        int s;
        s = 0;
        if (n == 8'd0) return 8'd0;
        for (int i = 0; i < 8; i++) s += int'(n[i]);
        for (int i = 7; i >= 0; i--) begin
            if (n[i]) begin
                s += i;
                break;
            end
        end
        return 8'(s);
    endfunction

    function automatic logic [15:0] pow_of(input logic [15:0] x, input logic [7:0] n);
        logic [15:0] r;
        r = 16'd1;
        for (int i = 0; i < int'(n); i++) r = r * x;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pu_busy <= 8'd0;
            pu_res  <= 16'd0;
        end else if (pu_start && pu_busy == 8'd0) begin
            pu_busy <= busy_of(pu_n);
            pu_res  <= pow_of(pu_x, pu_n);
        end else if (pu_busy != 8'd0) begin
            pu_busy <= pu_busy - 8'd1;
        end
    end

    assign pu_ready = (pu_busy == 8'd0);
    assign pu_out   = pu_res;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request, wait (bounded) for in_ready, then let the edge accept it.
    task automatic push(input logic [15:0] x, input logic [7:0] n);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_n     = n;
        while (in_ready !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk("push_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result, check it, and consume it with out_ready=1.
    task automatic wait_out(input string tag, input logic [15:0] exp);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 400) begin
            step();
            k++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk(tag, out_data, exp);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = 16'd0;
        in_n      = 8'd0;
        out_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_pu_start", pu_start, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        step();

        // (3,5): start only in cycle 1, result 243 in cycle 7
        push(16'd3, 8'd5);
        chk("t1_c0_count", count, 1);
        chk("t1_c0_start", pu_start, 0);
        for (int c = 1; c <= 7; c++) begin
            step();
            chk($sformatf("t1_c%0d_start", c), pu_start, (c == 1) ? 1 : 0);
            chk($sformatf("t1_c%0d_valid", c), out_valid, (c == 7) ? 1 : 0);
            if (c == 1) begin
                chk("t1_pu_x", pu_x, 3);
                chk("t1_pu_n", pu_n, 5);
            end
        end
        chk("t1_data", out_data, 243);
        step();
        chk("t1_valid_drop", out_valid, 0);
        chk("t1_count_end", count, 0);

        // (7,0): result 1 in cycle 3, one-cycle start pulse
        push(16'd7, 8'd0);
        step();
        chk("t2_c1_start", pu_start, 1);
        step();
        chk("t2_c2_start", pu_start, 0);
        chk("t2_c2_valid", out_valid, 0);
        step();
        chk("t2_c3_valid", out_valid, 1);
        chk("t2_c3_data", out_data, 1);
        step();
        chk("t2_valid_drop", out_valid, 0);

        // Back-to-back requests come out in order
        push(16'd2, 8'd16);
        push(16'd2, 8'd15);
        push(16'hFFFF, 8'd2);
        push(16'd5, 8'd3);
        wait_out("t3_r0", 16'h0000);
        wait_out("t3_r1", 16'h8000);
        wait_out("t3_r2", 16'h0001);
        wait_out("t3_r3", 16'd125);

        // Back-pressure: out_ready low, fill to DEPTH with one request in flight
        out_ready = 1'b0;
        push(16'd3, 8'd1);
        step();
        chk("t4_issue_start", pu_start, 1);
        chk("t4_issue_count", count, 1);
        push(16'd2, 8'd3);
        // push coinciding with the ISSUE pop leaves count at 1
        chk("t4_pushpop_count", count, 1);
        push(16'd10, 8'd2);
        chk("t4_count2", count, 2);
        push(16'd3, 8'd4);
        chk("t4_count3", count, 3);
        push(16'h0100, 8'd2);
        chk("t4_count4", count, 4);
        chk("t4_full_ready", in_ready, 0);
        // A sixth request waits while full; the held result must not move
        in_valid = 1'b1;
        in_x     = 16'd7;
        in_n     = 8'd3;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t4_hold%0d_count", c), count, 4);
            chk($sformatf("t4_hold%0d_ready", c), in_ready, 0);
            chk($sformatf("t4_hold%0d_valid", c), out_valid, 1);
            chk($sformatf("t4_hold%0d_data", c), out_data, 3);
            step();
        end
        out_ready = 1'b1;
        wait_out("t4_q0", 16'd3);
        push(16'd7, 8'd3);
        wait_out("t4_q1", 16'd8);
        wait_out("t4_q2", 16'd100);
        wait_out("t4_q3", 16'd81);
        wait_out("t4_q4", 16'h0000);
        wait_out("t4_q5", 16'h0157);
        chk("t4_count_end", count, 0);

        // Reset during WAIT of (3,200) abandons the job and the queue
        push(16'd3, 8'd200);
        step();
        step();
        step();
        push(16'd5, 8'd1);
        chk("t6_wait_valid", out_valid, 0);
        chk("t6_wait_count", count, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_start", pu_start, 0);
        chk("t6_rst_ready", in_ready, 1);
        step();
        rst = 1'b0;
        step();
        push(16'd3, 8'd2);
        wait_out("t6_after", 16'd9);
        for (int c = 0; c < 20; c++) begin
            step();
        end
        chk("t6_no_stale_valid", out_valid, 0);
        chk("t6_no_stale_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
